// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, next-PC select, SRAM drive,
// pending redirect across stalls and a hold buffer for the decode word.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    input  logic [31:0] inst_sram_rdata,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] id_inst
);

    localparam logic STOP   = 1'b1;
    localparam logic S_LIVE = 1'b0;
    localparam logic S_HELD = 1'b1;

    localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_pend_valid;
    logic [31:0] r_pend_addr;
    logic        r_hold_valid;
    logic [31:0] r_hold_inst;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic        w_if_stop;
    logic        w_id_stop;
    logic [31:0] w_next_pc;
    logic        w_unused;

    assign w_br_e    = br_bus[32];
    assign w_br_addr = br_bus[31:0];
    assign w_if_stop = (stall[0] == STOP);
    assign w_id_stop = (stall[1] == STOP);
    assign w_unused  = ^stall[5:2];

    // Next PC: live redirect beats a remembered one, else sequential.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (w_br_e) begin
            w_next_pc = w_br_addr;
        end else if (r_pend_valid) begin
            w_next_pc = r_pend_addr;
        end
    end

    // PC and fetch-enable advance only when IF is not stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc <= PC_INIT;
            r_ce <= 1'b0;
        end else if (!w_if_stop) begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

    // Remember a redirect seen while IF is stalled; latest one wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 32'd0;
        end else if (!w_if_stop) begin
            r_pend_valid <= 1'b0;
        end else if (w_br_e) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= w_br_addr;
        end
    end

    // Hold buffer: capture the live word on the first ID stall cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_valid <= S_LIVE;
            r_hold_inst  <= 32'd0;
        end else begin
            case (r_hold_valid)
                S_LIVE: begin
                    if (w_id_stop) begin
                        r_hold_inst  <= inst_sram_rdata;
                        r_hold_valid <= S_HELD;
                    end
                end
                default: begin
                    if (!w_id_stop) begin
                        r_hold_valid <= S_LIVE;
                    end
                end
            endcase
        end
    end

    assign inst_sram_en    = r_ce & ~w_if_stop;
    assign inst_sram_wen   = 4'd0;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wdata = 32'd0;
    assign if_to_id_bus    = {r_ce, r_pc};
    assign id_inst = (r_hold_valid == S_HELD) ? r_hold_inst
                                              : inst_sram_rdata;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table for fetch/redirect/stall corners,
// async-reset sequence, and a scoreboard for free-running fetch.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [31:0] inst_sram_rdata;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] id_inst;

    int n_chk = 0;
    int n_fail = 0;

    logic        ovr = 1'b0;
    logic [31:0] ovr_val = 32'hDEAD_BEEF;
    logic [31:0] sram_q = 32'd0;

    typedef struct {
        logic [5:0]  stall;
        logic        br_e;
        logic [31:0] br_addr;
        logic        ovr;
        logic [31:0] exp_addr;
        logic        exp_en;
        logic        exp_ce;
        logic        chk_id;
        logic [31:0] exp_id;
    } vec_t;

    vec_t vec[26];
    logic [31:0] sb_q[$];

    if_fetch dut (
        .clk(clk),
        .resetn(resetn),
        .stall(stall),
        .br_bus(br_bus),
        .inst_sram_rdata(inst_sram_rdata),
        .if_to_id_bus(if_to_id_bus),
        .inst_sram_en(inst_sram_en),
        .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C01_1234;
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (inst_sram_en) sram_q <= mem_fn(inst_sram_addr);
    end

    assign inst_sram_rdata = ovr ? ovr_val : sram_q;

    function automatic vec_t mk(
        input logic [5:0] s, input logic b, input logic [31:0] ba,
        input logic o, input logic [31:0] ea, input logic een,
        input logic ece, input logic ci, input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.br_e = b; v.br_addr = ba; v.ovr = o;
        v.exp_addr = ea; v.exp_en = een; v.exp_ce = ece;
        v.chk_id = ci; v.exp_id = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        vec[0]  = mk(6'd0, 0, 0, 0, 32'hBFBF_FFFC, 0, 0, 0, 0);
        vec[1]  = mk(6'd0, 0, 0, 0, 32'hBFC0_0000, 1, 1, 0, 0);
        vec[2]  = mk(6'd0, 0, 0, 0, 32'hBFC0_0004, 1, 1, 1, 32'h3C01_1234);
        vec[3]  = mk(6'd0, 1, 32'hBFC0_0100, 0, 32'hBFC0_0008, 1, 1, 1,
                     mem_fn(32'hBFC0_0004));
        vec[4]  = mk(6'd0, 0, 0, 0, 32'hBFC0_0100, 1, 1, 1,
                     mem_fn(32'hBFC0_0008));
        vec[5]  = mk(6'd3, 0, 0, 0, 32'hBFC0_0104, 0, 1, 1,
                     mem_fn(32'hBFC0_0100));
        vec[6]  = mk(6'd3, 0, 0, 1, 32'hBFC0_0104, 0, 1, 1,
                     mem_fn(32'hBFC0_0100));
        vec[7]  = mk(6'd3, 0, 0, 1, 32'hBFC0_0104, 0, 1, 1,
                     mem_fn(32'hBFC0_0100));
        vec[8]  = mk(6'd0, 0, 0, 1, 32'hBFC0_0104, 1, 1, 1,
                     mem_fn(32'hBFC0_0100));
        vec[9]  = mk(6'd0, 0, 0, 0, 32'hBFC0_0108, 1, 1, 1,
                     mem_fn(32'hBFC0_0104));
        vec[10] = mk(6'd3, 1, 32'hBFC0_0200, 0, 32'hBFC0_010C, 0, 1, 1,
                     mem_fn(32'hBFC0_0108));
        vec[11] = mk(6'd3, 0, 0, 0, 32'hBFC0_010C, 0, 1, 1,
                     mem_fn(32'hBFC0_0108));
        vec[12] = mk(6'd0, 0, 0, 0, 32'hBFC0_010C, 1, 1, 1,
                     mem_fn(32'hBFC0_0108));
        vec[13] = mk(6'd0, 0, 0, 0, 32'hBFC0_0200, 1, 1, 1,
                     mem_fn(32'hBFC0_010C));
        vec[14] = mk(6'd3, 1, 32'hBFC0_0300, 0, 32'hBFC0_0204, 0, 1, 1,
                     mem_fn(32'hBFC0_0200));
        vec[15] = mk(6'd0, 1, 32'hBFC0_0400, 0, 32'hBFC0_0204, 1, 1, 1,
                     mem_fn(32'hBFC0_0200));
        vec[16] = mk(6'd0, 0, 0, 0, 32'hBFC0_0400, 1, 1, 1,
                     mem_fn(32'hBFC0_0204));
        vec[17] = mk(6'd3, 1, 32'hBFC0_0500, 0, 32'hBFC0_0404, 0, 1, 1,
                     mem_fn(32'hBFC0_0400));
        vec[18] = mk(6'd3, 1, 32'hBFC0_0600, 0, 32'hBFC0_0404, 0, 1, 1,
                     mem_fn(32'hBFC0_0400));
        vec[19] = mk(6'd0, 0, 0, 0, 32'hBFC0_0404, 1, 1, 1,
                     mem_fn(32'hBFC0_0400));
        vec[20] = mk(6'd0, 0, 0, 0, 32'hBFC0_0600, 1, 1, 1,
                     mem_fn(32'hBFC0_0404));
        vec[21] = mk(6'd0, 1, 32'hFFFF_FFFC, 0, 32'hBFC0_0604, 1, 1, 1,
                     mem_fn(32'hBFC0_0600));
        vec[22] = mk(6'd0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 1,
                     mem_fn(32'hBFC0_0604));
        vec[23] = mk(6'd0, 1, 32'h0000_0002, 0, 32'h0000_0000, 1, 1, 1,
                     mem_fn(32'hFFFF_FFFC));
        vec[24] = mk(6'd0, 0, 0, 0, 32'h0000_0002, 1, 1, 1,
                     mem_fn(32'h0000_0000));
        vec[25] = mk(6'd0, 0, 0, 0, 32'h0000_0006, 1, 1, 1,
                     mem_fn(32'h0000_0002));

        resetn = 1'b0;
        stall  = 6'd0;
        br_bus = 33'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en", {31'd0, inst_sram_en}, 32'd0);
        chk("rst_addr", inst_sram_addr, 32'hBFBF_FFFC);
        chk("rst_ce", {31'd0, if_to_id_bus[32]}, 32'd0);
        chk("rst_bus_pc", if_to_id_bus[31:0], 32'hBFBF_FFFC);
        chk("rst_id", id_inst, inst_sram_rdata);
        chk("rst_wen", {28'd0, inst_sram_wen}, 32'd0);
        chk("rst_wdata", inst_sram_wdata, 32'd0);

        for (int i = 0; i < 26; i++) begin
            @(posedge clk);
            #1;
            resetn = 1'b1;
            stall  = vec[i].stall;
            br_bus = {vec[i].br_e, vec[i].br_addr};
            ovr    = vec[i].ovr;
            @(negedge clk);
            chk($sformatf("v%0d_addr", i), inst_sram_addr, vec[i].exp_addr);
            chk($sformatf("v%0d_en", i), {31'd0, inst_sram_en},
                {31'd0, vec[i].exp_en});
            chk($sformatf("v%0d_bus", i), if_to_id_bus[31:0],
                vec[i].exp_addr);
            chk($sformatf("v%0d_ce", i), {31'd0, if_to_id_bus[32]},
                {31'd0, vec[i].exp_ce});
            if (vec[i].chk_id)
                chk($sformatf("v%0d_id", i), id_inst, vec[i].exp_id);
        end

        @(posedge clk);
        #1;
        stall  = 6'd3;
        br_bus = {1'b1, 32'hBFC0_0700};
        @(posedge clk);
        #1;
        br_bus = 33'd0;
        @(negedge clk);
        ovr = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_en", {31'd0, inst_sram_en}, 32'd0);
        chk("arst_addr", inst_sram_addr, 32'hBFBF_FFFC);
        chk("arst_ce", {31'd0, if_to_id_bus[32]}, 32'd0);
        chk("arst_id", id_inst, 32'hDEAD_BEEF);
        ovr = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        stall  = 6'd0;
        @(negedge clk);
        chk("rel_addr", inst_sram_addr, 32'hBFBF_FFFC);

        begin
            logic [31:0] exp_pc;
            logic        b;
            logic [31:0] ba;
            exp_pc = 32'hBFC0_0000;
            for (int k = 0; k < 24; k++) begin
                @(posedge clk);
                #1;
                b  = ($urandom_range(0, 3) == 0);
                ba = {$urandom_range(0, 32'hFFFF), 16'd0} | 32'h0000_0100;
                br_bus = {b, ba};
                @(negedge clk);
                chk($sformatf("sb%0d_addr", k), inst_sram_addr, exp_pc);
                chk($sformatf("sb%0d_ce", k), {31'd0, if_to_id_bus[32]},
                    32'd1);
                if (sb_q.size() != 0)
                    chk($sformatf("sb%0d_id", k), id_inst, sb_q.pop_front());
                sb_q.push_back(mem_fn(exp_pc));
                exp_pc = b ? ba : exp_pc + 32'd4;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
